camera_line_packer: RTL

Reader side of the Camera Link receive FIFO: pops one completed line of 64-bit pixel words, prepends an 8-byte line header, and writes the line into the UDP transmit FIFO. Each line becomes one UDP datagram, started with `etx_enable`. Sits between the Camera Link receiver's output FIFO and the UDP core's TX path, in the controller clock domain (50 MHz).

---
 rtl/camlink_pkg.sv | 31 +++
 rtl/line_event_counter.sv | 49 ++++
 rtl/camera_line_packer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/camlink_pkg.sv
// camlink_pkg
// Shared types and constants for the camera line packer: FSM state encoding,
// line/UDP/IP header sizes, the line header magic word and a byte-to-word
// rounding helper.
package camlink_pkg;

  localparam int DATA_W          = 64;
  localparam int LINE_HDR_BYTES  = 8;
  localparam int UDP_HDR_BYTES   = 8;
  localparam int IPUDP_HDR_BYTES = 28;

  localparam logic [15:0] HDR_MAGIC = 16'hA55A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_COPY,
    ST_START,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_DROP
  } state_e;

  // Number of 64-bit words needed to hold 'bytes' bytes (ceil(bytes/8)).
  function automatic logic [13:0] words_ceil(input logic [15:0] bytes);
    logic [16:0] t;
    t = {1'b0, bytes} + 17'd7;
    return t[16:3];
  endfunction

endpackage

// File: rtl/line_event_counter.sv
// line_event_counter
// 4-bit up/down counter of completed lines waiting in the camera FIFO.
// An increment at full scale is discarded and latches a sticky overflow flag.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   inc_i      : one line completed
//   dec_i      : one line taken by the packer
//   count_o    : lines pending
//   ovf_o      : sticky, an increment was lost
module line_event_counter
  import camlink_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [3:0] count_o,
  output logic       ovf_o
);

  logic [3:0] count_q, count_d;
  logic       ovf_q, ovf_d;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    // Simultaneous inc and dec cancel, so they never touch the overflow flag.
    if (inc_i && !dec_i) begin
      if (count_q == 4'hF) ovf_d = 1'b1;
      else                 count_d = count_q + 4'd1;
    end else if (dec_i && !inc_i && count_q != 4'd0) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 4'd0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/camera_line_packer.sv
// camera_line_packer
// Pops one completed camera line from a first-word-fall-through FIFO, prefixes
// an 8-byte line header and writes the line into the UDP TX FIFO, then starts
// one datagram with etx_enable. Malformed lines are drained and counted.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   cam_dout/cam_empty/cam_rden: camera FIFO head, empty flag, pop
//   cam_data_length            : byte length of the newest completed line
//   cam_line_final             : one pulse per completed line
//   etx_din/ewr_en/etx_full    : UDP TX FIFO write port
//   etx_enable                 : start-datagram pulse
//   tx_data_length             : UDP length of the datagram
//   tx_total_length            : IP total length of the datagram
//   tx_busy                    : UDP core transmitting
//   line_count/drop_count      : lines sent (wrapping) / dropped (saturating)
//   pend_ovf                   : sticky pending-line counter overflow
module camera_line_packer
  import camlink_pkg::*;
#(
  parameter int MAX_BYTES = 1464,
  parameter int WAIT_TMO  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] cam_dout,
  input  logic              cam_empty,
  output logic              cam_rden,
  input  logic [15:0]       cam_data_length,
  input  logic              cam_line_final,
  output logic [DATA_W-1:0] etx_din,
  output logic              ewr_en,
  input  logic              etx_full,
  output logic              etx_enable,
  output logic [15:0]       tx_data_length,
  output logic [15:0]       tx_total_length,
  input  logic              tx_busy,
  output logic [15:0]       line_count,
  output logic [15:0]       drop_count,
  output logic              pend_ovf
);

  state_e      state_q;
  logic [15:0] last_len_q;     // length of the most recently completed line
  logic [15:0] len_q;          // length of the line being processed
  logic [13:0] cnt_q;          // words still to move (COPY) or discard (DROP)
  logic [7:0]  tmo_q;
  logic        etx_enable_q;
  logic [15:0] tx_data_length_q;
  logic [15:0] tx_total_length_q;
  logic [15:0] line_count_q;
  logic [15:0] drop_count_q;

  logic [3:0]  pend_cnt;
  logic        accept;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign accept = (state_q == ST_IDLE) && (pend_cnt != 4'd0) && !tx_busy;

  line_event_counter u_pend (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (cam_line_final),
    .dec_i   (accept),
    .count_o (pend_cnt),
    .ovf_o   (pend_ovf)
  );

  // FIFO handshakes are combinational so a stalled cycle never pops or writes.
  always_comb begin
    cam_rden = 1'b0;
    ewr_en   = 1'b0;
    etx_din  = '0;
    case (state_q)
      ST_HDR: begin
        ewr_en  = !etx_full;
        etx_din = {HDR_MAGIC, line_count_q, len_q, 16'h0000};
      end
      ST_COPY: begin
        cam_rden = !cam_empty && !etx_full;
        ewr_en   = !cam_empty && !etx_full;
        etx_din  = cam_dout;
      end
      ST_DROP: cam_rden = !cam_empty;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      last_len_q        <= 16'd0;
      len_q             <= 16'd0;
      cnt_q             <= 14'd0;
      tmo_q             <= 8'd0;
      etx_enable_q      <= 1'b0;
      tx_data_length_q  <= 16'd0;
      tx_total_length_q <= 16'd0;
      line_count_q      <= 16'd0;
      drop_count_q      <= 16'd0;
    end else begin
      etx_enable_q <= 1'b0;
      if (cam_line_final) last_len_q <= cam_data_length;

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            len_q <= last_len_q;
            if (last_len_q == 16'd0) begin
              drop_count_q <= sat_inc16(drop_count_q);
            end else if (last_len_q > 16'(MAX_BYTES) || last_len_q[2:0] != 3'd0) begin
              cnt_q   <= words_ceil(last_len_q);
              state_q <= ST_DROP;
            end else begin
              cnt_q   <= {1'b0, last_len_q[15:3]};
              state_q <= ST_HDR;
            end
          end
        end
        ST_HDR: begin
          if (!etx_full) state_q <= ST_COPY;
        end
        ST_COPY: begin
          if (cam_rden) begin
            cnt_q <= cnt_q - 14'd1;
            if (cnt_q == 14'd1) state_q <= ST_START;
          end
        end
        ST_START: begin
          etx_enable_q      <= 1'b1;
          tx_data_length_q  <= len_q + 16'(UDP_HDR_BYTES + LINE_HDR_BYTES);
          tx_total_length_q <= len_q + 16'(LINE_HDR_BYTES + IPUDP_HDR_BYTES);
          line_count_q      <= line_count_q + 16'd1;
          tmo_q             <= 8'd0;
          state_q           <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          // Give up if the UDP core never acknowledges the start pulse.
          if (tx_busy)                         state_q <= ST_WAIT_LO;
          else if (tmo_q == 8'(WAIT_TMO - 1))  state_q <= ST_IDLE;
          else                                 tmo_q   <= tmo_q + 8'd1;
        end
        ST_WAIT_LO: begin
          if (!tx_busy) state_q <= ST_IDLE;
        end
        ST_DROP: begin
          if (cam_rden) begin
            cnt_q <= cnt_q - 14'd1;
            if (cnt_q == 14'd1) begin
              drop_count_q <= sat_inc16(drop_count_q);
              state_q      <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign etx_enable      = etx_enable_q;
  assign tx_data_length  = tx_data_length_q;
  assign tx_total_length = tx_total_length_q;
  assign line_count      = line_count_q;
  assign drop_count      = drop_count_q;

endmodule
